seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen_if.sv | 26 ++
 rtl/seq_gen.sv | 140 ++++++++++++++
 tb/tb_seq_gen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_if.sv
// Handshake bundle for seq_gen: request/pattern inputs from the master,
// serial data and status back from the generator.
interface seq_gen_if #(
  parameter int PAT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pat;
  logic [3:0]       reps;
  logic [1:0]       gap;
  logic             abort;
  logic             x;
  logic             x_vld;
  logic             busy;
  logic             done;
  logic [3:0]       sent;

  modport master (
    output start, pat, reps, gap, abort,
    input  x, x_vld, busy, done, sent
  );

  modport slave (
    input  start, pat, reps, gap, abort,
    output x, x_vld, busy, done, sent
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a latched pattern MSB first, reps times,
// with gap idle cycles between repeats, then pulses done.
module seq_gen #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_DEF = 4'b1101
) (
  input logic   clk,
  input logic   rst,
  seq_gen_if.slave bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       gcnt_q, gcnt_d;
  logic [3:0]       reps_q, reps_d;
  logic [1:0]       gap_q, gap_d;
  logic [3:0]       sent_q, sent_d;
  logic             x_q, x_d;
  logic             x_vld_q, x_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    sent_d  = sent_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort && (bus.reps != 4'd0)) begin
          state_d = S_SEND;
          shreg_d = bus.pat;
          reps_d  = bus.reps;
          gap_d   = bus.gap;
          sent_d  = 4'd0;
          idx_d   = IDX_LAST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          // Rotate so the register is back to the original pattern after PAT_W bits.
          shreg_d = (shreg_q << 1) | (shreg_q >> (PAT_W - 1));
          if (idx_q == '0) begin
            sent_d = sent_q + 4'd1;
            if (sent_d == reps_q) begin
              state_d = S_DONE;
            end else if (gap_q == 2'd0) begin
              idx_d = IDX_LAST;
            end else begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          gcnt_d  = 2'd0;
        end else if (gcnt_q == 2'd1) begin
          state_d = S_SEND;
          gcnt_d  = 2'd0;
          idx_d   = IDX_LAST;
        end else begin
          gcnt_d = gcnt_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    x_d     = (state_d == S_SEND) ? shreg_d[PAT_W-1] : 1'b0;
    x_vld_d = (state_d == S_SEND);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shreg_q <= PAT_DEF;
      idx_q   <= '0;
      gcnt_q  <= 2'd0;
      reps_q  <= 4'd0;
      gap_q   <= 2'd0;
      sent_q  <= 4'd0;
      x_q     <= 1'b0;
      x_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      sent_q  <= sent_d;
      x_q     <= x_d;
      x_vld_q <= x_vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.x_vld = x_vld_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sent  = sent_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a queue-based model of the expected output stream checked
// every cycle, plus directed runs with hand-computed bit sequences.
module tb_seq_gen;

  logic clk;
  logic rst;

  seq_gen_if #(.PAT_W(4)) bus ();

  seq_gen #(.PAT_W(4), .PAT_DEF(4'b1101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       xv;
    logic       vl;
    logic       bz;
    logic       dn;
    logic [3:0] st;
  } ent_t;

  ent_t       exp_q[$];
  logic [3:0] idle_sent = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One entry per output cycle of a whole run, built when the request is accepted.
  task automatic model_load(input logic [3:0] p, input logic [3:0] r, input logic [1:0] g);
    ent_t e;
    for (int k = 0; k < int'(r); k++) begin
      for (int b = 3; b >= 0; b--) begin
        e = '{p[b], 1'b1, 1'b1, 1'b0, 4'(k)};
        exp_q.push_back(e);
      end
      if (k < int'(r) - 1) begin
        for (int j = 0; j < int'(g); j++) begin
          e = '{1'b0, 1'b0, 1'b1, 1'b0, 4'(k + 1)};
          exp_q.push_back(e);
        end
      end
    end
    e = '{1'b0, 1'b0, 1'b1, 1'b1, r};
    exp_q.push_back(e);
  endtask

  initial begin
    ent_t cur_m;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        idle_sent = 4'd0;
      end else if (exp_q.size() != 0) begin
        cur_m = exp_q[0];
        if (bus.abort && !cur_m.dn) begin
          exp_q.delete();
          idle_sent = cur_m.st;
        end else begin
          void'(exp_q.pop_front());
          if (cur_m.dn) idle_sent = cur_m.st;
        end
      end else if (bus.start && !bus.abort && (bus.reps != 4'd0)) begin
        model_load(bus.pat, bus.reps, bus.gap);
      end
    end
  end

  initial begin
    ent_t cur;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) cur = exp_q[0];
      else cur = '{1'b0, 1'b0, 1'b0, 1'b0, idle_sent};
      check("cycle", 32'({bus.x, bus.x_vld, bus.busy, bus.done, bus.sent}), 32'(cur));
    end
  end

  // Issue a request and collect the serial trace up to the done pulse.
  task automatic run_case(input string name, input logic [3:0] p, input logic [3:0] r,
                          input logic [1:0] g, input logic [31:0] exp_x, input logic [31:0] exp_v,
                          input int exp_len, input logic [3:0] exp_sent, input bit chg);
    logic [31:0] x_tr = 32'd0;
    logic [31:0] v_tr = 32'd0;
    int          len  = 0;
    bit          seen = 1'b0;
    bus.pat   = p;
    bus.reps  = r;
    bus.gap   = g;
    bus.start = 1'b1;
    @(negedge clk);
    if (chg) begin
      bus.pat  = 4'b0000;
      bus.reps = 4'd9;
      bus.gap  = 2'd3;
    end else begin
      bus.start = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 1) bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      x_tr = {x_tr[30:0], bus.x};
      v_tr = {v_tr[30:0], bus.x_vld};
      len++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_len"}, 32'(len), 32'(exp_len));
    check({name, "_x"}, x_tr, exp_x);
    check({name, "_xvld"}, v_tr, exp_v);
    check({name, "_sent_at_done"}, 32'(bus.sent), 32'(exp_sent));
    @(negedge clk);
    check({name, "_done_once"}, 32'(bus.done), 32'd0);
    check({name, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({name, "_sent_hold"}, 32'(bus.sent), 32'(exp_sent));
  endtask

  initial begin
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.pat   = 4'b0000;
    bus.reps  = 4'd0;
    bus.gap   = 2'd0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sent", 32'(bus.sent), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_case("r1", 4'b1101, 4'd1, 2'd0, 32'b1101, 32'b1111, 4, 4'd1, 1'b0);
    run_case("r2", 4'b1101, 4'd2, 2'd2, 32'b1101001101, 32'b1111001111, 10, 4'd2, 1'b0);
    run_case("r3", 4'b1011, 4'd3, 2'd0, 32'b101110111011, 32'hfff, 12, 4'd3, 1'b0);
    run_case("latched", 4'b1101, 4'd1, 2'd0, 32'b1101, 32'b1111, 4, 4'd1, 1'b1);

    // Zero repetitions are ignored and sent keeps its previous value.
    bus.pat   = 4'b1111;
    bus.reps  = 4'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reps0_busy", 32'(bus.busy), 32'd0);
      check("reps0_done", 32'(bus.done), 32'd0);
      check("reps0_sent", 32'(bus.sent), 32'd1);
      @(negedge clk);
    end

    // Abort during the second SEND cycle.
    bus.pat   = 4'b1101;
    bus.reps  = 4'd2;
    bus.gap   = 2'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_pre_x", 32'(bus.x), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_x", 32'(bus.x), 32'd0);
    check("abort_xvld", 32'(bus.x_vld), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sent", 32'(bus.sent), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", 32'({bus.done, bus.busy}), 32'd0);
      @(negedge clk);
    end
    run_case("post_abort", 4'b0110, 4'd1, 2'd0, 32'b0110, 32'b1111, 4, 4'd1, 1'b0);

    // Abort in IDLE wins over start.
    bus.reps  = 4'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("idle_abort_busy", 32'(bus.busy), 32'd0);

    // Reset while in the gap between patterns.
    bus.pat   = 4'b1101;
    bus.reps  = 4'd2;
    bus.gap   = 2'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("gap_busy", 32'(bus.busy), 32'd1);
    check("gap_sent", 32'(bus.sent), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_x", 32'(bus.x), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_sent", 32'(bus.sent), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({bus.busy, bus.x_vld}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_case("first_edge", 4'b1001, 4'd1, 2'd1, 32'b1001, 32'b1111, 4, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
